// File: rtl/asc_shift_sequencer_if.sv
// Control, status and snapshot-stream signals of the ascending-range shift sequencer.
// master = sequencer side, slave = config master plus trace sink.
interface asc_shift_sequencer_if #(
    parameter int W = 8,
    parameter int H = 7
);
    logic          start;
    logic [7:0]    nshift;
    logic [0:W-1]  v_w;
    logic [-H:H]   v_s;
    logic          snap_valid;
    logic          snap_ready;
    logic [31:0]   cyc;
    logic          busy;
    logic          done;

    modport master (
        input  start, nshift, snap_ready,
        output v_w, v_s, snap_valid, cyc, busy, done
    );

    modport slave (
        output start, nshift, snap_ready,
        input  v_w, v_s, snap_valid, cyc, busy, done
    );
endinterface

// File: rtl/asc_shift_sequencer.sv
// Loads two ascending-range vectors to all-ones, then left-shifts them nshift times,
// offering a valid/ready snapshot after the load and after each step; stalls in SNAP under back-pressure.
module asc_shift_sequencer #(
    parameter int W = 8,
    parameter int H = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    asc_shift_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SNAP,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [0:W-1]  v_w_q, v_w_d;
    logic [-H:H]   v_s_q, v_s_d;
    logic [7:0]    remaining_q, remaining_d;
    logic [31:0]   cyc_q, cyc_d;
    logic          snap_valid_q, snap_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d     = state_q;
        v_w_d       = v_w_q;
        v_s_d       = v_s_q;
        remaining_d = remaining_q;
        cyc_d       = cyc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.nshift;
                    cyc_d       = 32'd0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                v_w_d   = '1;
                v_s_d   = '1;
                state_d = S_SNAP;
            end
            S_SNAP: begin
                if (bus.snap_ready) begin
                    state_d = (remaining_q == 8'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Index 0 / -H is the MSB, so a plain << moves bits toward the low index.
                v_w_d       = v_w_q << 1;
                v_s_d       = v_s_q << 1;
                remaining_d = remaining_q - 8'd1;
                cyc_d       = cyc_q + 32'd1;
                state_d     = S_SNAP;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they register in step with it.
        snap_valid_d = (state_d == S_SNAP);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            v_w_q        <= '0;
            v_s_q        <= '0;
            remaining_q  <= 8'd0;
            cyc_q        <= 32'd0;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_w_q        <= v_w_d;
            v_s_q        <= v_s_d;
            remaining_q  <= remaining_d;
            cyc_q        <= cyc_d;
            snap_valid_q <= snap_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.v_w        = v_w_q;
    assign bus.v_s        = v_s_q;
    assign bus.cyc        = cyc_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_asc_shift_sequencer.sv
// Self-checking bench for asc_shift_sequencer: directed scenarios plus randomized counts and stalls,
// checked against a per-index model of which vector bits are cleared after k shifts.
module tb_asc_shift_sequencer;
    localparam int W = 8;
    localparam int H = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    asc_shift_sequencer_if #(.W(W), .H(H)) bus ();

    asc_shift_sequencer #(.W(W), .H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // After k shifts, index i of v_w is cleared iff i >= W-k.
    function automatic logic [0:W-1] exp_vw(input int k);
        logic [0:W-1] r;
        for (int i = 0; i < W; i++) r[i] = (i >= W - k) ? 1'b0 : 1'b1;
        return r;
    endfunction

    // After k shifts, index i of v_s is cleared iff i >= H-k+1.
    function automatic logic [-H:H] exp_vs(input int k);
        logic [-H:H] r;
        for (int i = -H; i <= H; i++) r[i] = (i >= H - k + 1) ? 1'b0 : 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full sequence. stall_at/stall_len force a stall at one snapshot; rnd_stall adds random stalls
    // elsewhere; poke sets start with nshift=5 during the first SHIFT cycle.
    task automatic run_seq(input string name, input int n, input int stall_at, input int stall_len,
                           input bit rnd_stall, input bit poke);
        int e;
        int total_stall;
        int s;
        logic [0:W-1] hold_w;
        logic [-H:H]  hold_s;
        e = 0;
        total_stall = 0;
        bus.nshift = n[7:0];
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        bus.nshift = 8'($urandom_range(0, 255));
        checks++;
        if (bus.busy !== 1'b1 || bus.snap_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_e0: busy=%b valid=%b, required busy=1 valid=0", name, bus.busy, bus.snap_valid);
        end
        bus.snap_ready = 1'($urandom_range(0, 1));
        step();
        e++;
        for (int k = 0; k <= n; k++) begin
            checks++;
            if (bus.snap_valid !== 1'b1 || bus.v_w !== exp_vw(k) || bus.v_s !== exp_vs(k) || bus.cyc !== 32'(k)) begin
                errors++;
                $display("FAIL %s snap%0d: valid=%b v_w=%h v_s=%h cyc=%0d, required valid=1 v_w=%h v_s=%h cyc=%0d",
                         name, k, bus.snap_valid, bus.v_w, bus.v_s, bus.cyc, exp_vw(k), exp_vs(k), k);
            end
            s = (k == stall_at) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            hold_w = bus.v_w;
            hold_s = bus.v_s;
            for (int j = 0; j < s; j++) begin
                bus.snap_ready = 1'b0;
                step();
                e++;
                total_stall++;
                checks++;
                if (bus.snap_valid !== 1'b1 || bus.v_w !== hold_w || bus.v_s !== hold_s) begin
                    errors++;
                    $display("FAIL %s stall%0d_%0d: valid=%b v_w=%h v_s=%h, required valid=1 v_w=%h v_s=%h",
                             name, k, j, bus.snap_valid, bus.v_w, bus.v_s, hold_w, hold_s);
                end
            end
            bus.snap_ready = 1'b1;
            step();
            e++;
            if (k < n) begin
                checks++;
                if (bus.snap_valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s shift%0d: valid=%b busy=%b done=%b, required 0/1/0",
                             name, k, bus.snap_valid, bus.busy, bus.done);
                end
                bus.snap_ready = 1'($urandom_range(0, 1));
                if (poke && k == 0) begin
                    bus.start  = 1'b1;
                    bus.nshift = 8'd5;
                end
                step();
                e++;
                bus.start = 1'b0;
            end
        end
        checks++;
        if (bus.done !== 1'b1 || e != 2 + 2 * n + total_stall || bus.cyc !== 32'(n)) begin
            errors++;
            $display("FAIL %s done_edge: done=%b edge=E%0d cyc=%0d, required done=1 edge=E%0d cyc=%0d",
                     name, bus.done, e, bus.cyc, 2 + 2 * n + total_stall, n);
        end
        bus.snap_ready = 1'b0;
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.snap_valid !== 1'b0 ||
            bus.v_w !== exp_vw(n) || bus.v_s !== exp_vs(n) || bus.cyc !== 32'(n)) begin
            errors++;
            $display("FAIL %s idle_after: done=%b busy=%b valid=%b v_w=%h v_s=%h cyc=%0d, required 0/0/0 %h %h %0d",
                     name, bus.done, bus.busy, bus.snap_valid, bus.v_w, bus.v_s, bus.cyc, exp_vw(n), exp_vs(n), n);
        end
        // Idle cycles with start low must hold everything and produce no further done pulse.
        for (int j = 0; j < 3; j++) begin
            step();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cyc !== 32'(n) || bus.v_w !== exp_vw(n)) begin
                errors++;
                $display("FAIL %s idle_hold%0d: done=%b busy=%b cyc=%0d v_w=%h, required 0/0/%0d/%h",
                         name, j, bus.done, bus.busy, bus.cyc, bus.v_w, n, exp_vw(n));
            end
        end
    endtask

    task automatic test_reset();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.v_w !== '0 || bus.v_s !== '0 || bus.cyc !== 32'd0 || bus.snap_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: v_w=%h v_s=%h cyc=%0d valid=%b busy=%b done=%b, required all 0",
                     bus.v_w, bus.v_s, bus.cyc, bus.snap_valid, bus.busy, bus.done);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_normal();
        run_seq("normal_n2", 2, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_seq("backpressure", 2, 1, 3, 1'b0, 1'b0);
    endtask

    task automatic test_zero_overshoot();
        run_seq("zero_n0", 0, -1, 0, 1'b0, 1'b0);
        run_seq("overshoot_n20", 20, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_seq("start_busy", 3, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        bus.nshift = 8'd3;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.snap_ready = 1'b1;
        step();
        step();
        bus.snap_ready = 1'b0;
        step();
        checks++;
        if (bus.snap_valid !== 1'b1 || bus.v_w !== exp_vw(1)) begin
            errors++;
            $display("FAIL midrst_pre: valid=%b v_w=%h, required 1 %h", bus.snap_valid, bus.v_w, exp_vw(1));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.v_w !== '0 || bus.v_s !== '0 || bus.cyc !== 32'd0 || bus.snap_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: v_w=%h v_s=%h cyc=%0d valid=%b busy=%b done=%b, required all 0",
                     bus.v_w, bus.v_s, bus.cyc, bus.snap_valid, bus.busy, bus.done);
        end
        step();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_nodone%0d: done=%b busy=%b, required 0/0", j, bus.done, bus.busy);
            end
        end
        run_seq("after_reset_n1", 1, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            run_seq($sformatf("random%0d", r), int'($urandom_range(0, 20)), -1, 0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.nshift     = 8'd0;
        bus.snap_ready = 1'b0;
        test_reset();
        test_normal();
        test_backpressure();
        test_zero_overshoot();
        test_start_while_busy();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/asc_shift_sequencer.md
# asc_shift_sequencer

Sequencer for a pair of ascending-range shift registers: one vector indexed `[0:W-1]` and one indexed `[-H:H]`. On `start` it loads both vectors to all-ones, then performs a programmed number of left-shift steps. After the load and after every step it presents a snapshot to a downstream trace sink over a valid/ready handshake, and it stalls while the sink back-pressures. The block sits between a test/config master and the trace-capture path.

## Interface
- `W`, default 8: width of `v_w`, declared `[0:W-1]`; W ≥ 1.
- `H`, default 7: half-range of `v_s`, declared `[-H:H]`, width 2H+1; H ≥ 1.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `nshift`  in  8  number of shift steps; latched when `start` is accepted.
- `v_w`  out  [0:W-1]  ascending-range vector; index 0 is MSB.
- `v_s`  out  [-H:H]  ascending-range vector; index -H is MSB.
- `snap_valid`  out  1  snapshot of `v_w`/`v_s` available.
- `snap_ready`  in  1  sink accepts the snapshot.
- `cyc`  out  32  shift steps performed in the current or last sequence.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at sequence end.

## Operation
- States: IDLE, LOAD, SNAP, SHIFT, DONE. All outputs are registered.
- IDLE: if `start` = 1, latch `nshift` into `remaining`, clear `cyc` to 0, and go to LOAD. Otherwise hold all outputs.
- LOAD: `v_w` <= all ones, `v_s` <= all ones, go to SNAP.
- SNAP: `snap_valid` = 1. `v_w` and `v_s` hold.
  - On `snap_ready` = 1: if `remaining` = 0, go to DONE; else go to SHIFT.
  - On `snap_ready` = 0: stay in SNAP.
- SHIFT: `v_w` <= `v_w` << 1 and `v_s` <= `v_s` << 1.
  - A left shift moves bits toward the MSB index and zero-fills the LSB index (W-1 for `v_w`, H for `v_s`).
  - `remaining` -= 1, `cyc` += 1, go to SNAP.
- DONE: `done` = 1 for this one cycle, then go to IDLE. The vectors and `cyc` hold their final values until the next LOAD or reset.
- After k shifts:
  - `v_w` indices W-k..W-1 are 0 and all other indices are 1.
  - `v_s` indices H-k+1..H are 0 and all other indices are 1.
  - Once k ≥ width, the vector is all zero. This is legal and there is no saturation flag.
- `start` outside IDLE is ignored. It is neither queued nor does it restart the sequence.
- `nshift` = 0 gives LOAD, one SNAP, then DONE.
- `cyc` is 32 bits and cannot wrap, because `nshift` ≤ 255.

## Timing
- Reset (asynchronous, immediate) forces: state IDLE, `v_w` = 0, `v_s` = 0, `cyc` = 0, `remaining` = 0, `snap_valid` = 0, `busy` = 0, `done` = 0.
- Reset asserted mid-sequence, in any state, aborts the sequence with no `done` pulse. The first `start` after deassertion is honoured normally.
- Handshake rules:
  - Once `snap_valid` rises, it stays high and `v_w`/`v_s` stay stable until the edge where `snap_ready` = 1.
  - `snap_valid` never depends combinationally on `snap_ready`.
  - `snap_ready` high while `snap_valid` is low has no effect.
- Latency with `snap_ready` tied high, where E0 is the edge that samples `start`:
  - E1: LOAD completes; the all-ones vectors and `snap_valid` are visible after E1.
  - Each shift step costs 2 cycles (SHIFT, then SNAP).
  - The final snapshot is accepted at E(2+2N).
  - `done` is high between E(2+2N) and E(3+2N).
  - `busy` is back to 0 after E(3+2N).
- Each cycle of `snap_ready` = 0 during SNAP adds exactly one cycle.
- `busy` rises after E0 and falls on the DONE→IDLE edge.
- A `start` held high through DONE is accepted on the first cycle back in IDLE.

## Test plan
- **Reset values:** assert `rst` asynchronously, with no clock edge. Then all outputs = 0 and `busy` = 0.
- **Normal sequence:** W=8, H=7, `nshift`=2, ready tied 1, pulse `start`. Snapshots must be `v_w` = FF, FE, FC and `v_s` = 7FFF, 7FFE, 7FFC. `done` is high exactly between E6 and E7, and `cyc` = 2.
- **Back-pressure:** hold `snap_ready` = 0 for 3 cycles at the second snapshot. `snap_valid` stays 1 and `v_w` = FE is unchanged for those 3 cycles. `done` is delayed by exactly 3 cycles.
- **Zero and overshoot counts:**
  - `nshift`=0 gives one snapshot (FF/7FFF), then `done` at E2–E3.
  - `nshift`=20 gives `v_w` = 00 after step 8 and `v_s` = 0000 after step 15. `cyc` = 20 at `done`.
- **Start while busy:** pulse `start` with `nshift`=5 during the SHIFT of an `nshift`=3 run. The run ends with `cyc` = 3 and a single `done` pulse.
- **Reset mid-run:** assert `rst` during SNAP of step 1. All outputs go to 0 with no `done` pulse. A following `start` with `nshift`=1 yields FF, then FE.
